// File: rtl/slot_allocator_pkg.sv
// Shared types and helpers for the parking slot allocator.
// Slot numbers are 1-based on the ports; flag vectors are 0-based (bit 0 = slot 1).
package slot_allocator_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_WAIT = 2'd1,
    EXIT_WAIT  = 2'd2
  } state_t;

  localparam int         NUM_SLOTS = 3;
  localparam logic [1:0] SLOT_NONE = 2'd0;

  // One-hot flag mask for a 1-based slot number; slot 0 maps to no bits.
  function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [1:0] slot);
    case (slot)
      2'd1:    slot_mask = 3'b001;
      2'd2:    slot_mask = 3'b010;
      2'd3:    slot_mask = 3'b100;
      default: slot_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] slot_count(input logic [NUM_SLOTS-1:0] flags);
    slot_count = {1'b0, flags[0]} + {1'b0, flags[1]} + {1'b0, flags[2]};
  endfunction

endpackage

// File: rtl/slot_allocator_if.sv
// Request/response bundle between the gate controls and the slot allocator.
interface slot_allocator_if;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_slot;
  logic       pass_sensor;
  logic       car1_state;
  logic       car2_state;
  logic       car3_state;
  logic [1:0] occupancy;
  logic       gate_open;
  logic [1:0] assigned_slot;
  logic       grant;
  logic       deny;

  modport master (
    output entry_req, exit_req, exit_slot, pass_sensor,
    input  car1_state, car2_state, car3_state, occupancy,
    input  gate_open, assigned_slot, grant, deny
  );

  modport slave (
    input  entry_req, exit_req, exit_slot, pass_sensor,
    output car1_state, car2_state, car3_state, occupancy,
    output gate_open, assigned_slot, grant, deny
  );
endinterface

// File: rtl/slot_allocator_free_slot_enc.sv
// Priority encoder: lowest-numbered free slot from the committed occupancy flags.
module free_slot_enc
  import slot_allocator_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] occ_vec,
  output logic [1:0]           slot,
  output logic                 any_free
);

  // Slot 1 has highest priority.
  always_comb begin
    slot     = SLOT_NONE;
    any_free = 1'b1;
    if (!occ_vec[0]) begin
      slot = 2'd1;
    end else if (!occ_vec[1]) begin
      slot = 2'd2;
    end else if (!occ_vec[2]) begin
      slot = 2'd3;
    end else begin
      slot     = SLOT_NONE;
      any_free = 1'b0;
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// Three-slot car park allocator: arbitrates entry/exit requests, drives the
// barrier and commits slot occupancy only once a car has crossed the gate.
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int GATE_TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            reset,
  slot_allocator_if.slave bus
);

  logic [1:0]           rst_sync_r;
  logic                 rst_n_s;
  state_t               state_r, state_next_s;
  logic [NUM_SLOTS-1:0] slots_r, slots_next_s;
  logic [NUM_SLOTS-1:0] exit_mask_r, exit_mask_next_s, exit_req_mask_s;
  logic [1:0]           assigned_r, assigned_next_s;
  logic [1:0]           occupancy_r;
  logic                 gate_open_r, gate_next_s;
  logic                 grant_r, grant_next_s;
  logic                 deny_r, deny_next_s;
  logic [15:0]          timer_r;
  logic [1:0]           free_slot_s;
  logic                 any_free_s;
  logic                 exit_hit_s;
  logic                 timeout_s;

  // Reset asserts immediately, releases two clock edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  free_slot_enc u_free_slot_enc (
    .occ_vec  (slots_r),
    .slot     (free_slot_s),
    .any_free (any_free_s)
  );

  assign exit_req_mask_s = slot_mask(bus.exit_slot);
  assign exit_hit_s      = |(exit_req_mask_s & slots_r);
  assign timeout_s       = (timer_r == 16'(GATE_TIMEOUT - 1));

  // Transaction sequencing; exit beats entry, pass_sensor beats timeout.
  always_comb begin
    state_next_s     = state_r;
    slots_next_s     = slots_r;
    exit_mask_next_s = exit_mask_r;
    assigned_next_s  = assigned_r;
    gate_next_s      = gate_open_r;
    grant_next_s     = 1'b0;
    deny_next_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.exit_req) begin
          if (exit_hit_s) begin
            grant_next_s     = 1'b1;
            gate_next_s      = 1'b1;
            exit_mask_next_s = exit_req_mask_s;
            state_next_s     = EXIT_WAIT;
          end else begin
            deny_next_s = 1'b1;
          end
        end else if (bus.entry_req) begin
          if (any_free_s) begin
            grant_next_s    = 1'b1;
            gate_next_s     = 1'b1;
            assigned_next_s = free_slot_s;
            state_next_s    = ENTRY_WAIT;
          end else begin
            deny_next_s = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ENTRY_WAIT: begin
        if (bus.pass_sensor) begin
          slots_next_s    = slots_r | slot_mask(assigned_r);
          assigned_next_s = SLOT_NONE;
          gate_next_s     = 1'b0;
          state_next_s    = IDLE;
        end else if (timeout_s) begin
          assigned_next_s = SLOT_NONE;
          deny_next_s     = 1'b1;
          gate_next_s     = 1'b0;
          state_next_s    = IDLE;
        end else begin
          state_next_s = ENTRY_WAIT;
        end
      end
      EXIT_WAIT: begin
        if (bus.pass_sensor) begin
          slots_next_s     = slots_r & ~exit_mask_r;
          exit_mask_next_s = 3'b000;
          gate_next_s      = 1'b0;
          state_next_s     = IDLE;
        end else if (timeout_s) begin
          exit_mask_next_s = 3'b000;
          deny_next_s      = 1'b1;
          gate_next_s      = 1'b0;
          state_next_s     = IDLE;
        end else begin
          state_next_s = EXIT_WAIT;
        end
      end
      default: begin
        state_next_s     = IDLE;
        exit_mask_next_s = 3'b000;
        assigned_next_s  = SLOT_NONE;
        gate_next_s      = 1'b0;
      end
    endcase
  end

  // State and registered outputs; occupancy is recomputed from the flags it mirrors.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r     <= IDLE;
      slots_r     <= 3'b000;
      exit_mask_r <= 3'b000;
      assigned_r  <= SLOT_NONE;
      occupancy_r <= 2'd0;
      gate_open_r <= 1'b0;
      grant_r     <= 1'b0;
      deny_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      slots_r     <= slots_next_s;
      exit_mask_r <= exit_mask_next_s;
      assigned_r  <= assigned_next_s;
      occupancy_r <= slot_count(slots_next_s);
      gate_open_r <= gate_next_s;
      grant_r     <= grant_next_s;
      deny_r      <= deny_next_s;
    end
  end

  // Gate timer: zero in IDLE and on entry to a wait state, counts while waiting.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      timer_r <= 16'd0;
    end else if ((state_r != IDLE) && (state_next_s == state_r)) begin
      timer_r <= timer_r + 16'd1;
    end else begin
      timer_r <= 16'd0;
    end
  end

  assign bus.car1_state    = slots_r[0];
  assign bus.car2_state    = slots_r[1];
  assign bus.car3_state    = slots_r[2];
  assign bus.occupancy     = occupancy_r;
  assign bus.gate_open     = gate_open_r;
  assign bus.assigned_slot = assigned_r;
  assign bus.grant         = grant_r;
  assign bus.deny          = deny_r;

endmodule
